alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing controller that shares one combinational ALU (5-bit opcode, 32-bit operands, overflow flag) between two requesters. Each requester issues operations over a valid/ready handshake. The block grants requesters in round-robin order, registers the opcode and operands, drives the ALU for exactly one cycle, and captures the result. It then returns the result to the granted requester over a response valid/ready handshake. It sits between the register-file/issue logic and the ALU instance, and is the only driver of the ALU inputs.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 5, ALU opcode width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle when valid && ready
- req0_op / req1_op  in  OP_W  ALU opcode
- req0_src1 / req1_src1, req0_src2 / req1_src2  in  DATA_W  operands
- rsp0_valid / rsp1_valid  out  1  result held for that requester
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- rsp_data  out  DATA_W  result (shared, qualified by rspX_valid)
- rsp_overflow  out  1  ALU overflow flag of that result
- alu_enable  out  1  ALU enable
- alu_op  out  OP_W  ALU opcode
- alu_src1 / alu_src2  out  DATA_W  ALU operands
- alu_result  in  DATA_W  ALU output
- alu_ovf  in  1  ALU overflow
- ovf_sticky0 / ovf_sticky1  out  1  sticky overflow per requester (see Configuration)
- ovf_clr  in  1  clears both sticky flags

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - grant = requester with valid; if both are valid, grant the one not granted last (last_grant resets to 1, so req0 wins first).
  - reqX_ready = (state==IDLE) && grant==X. The ready may depend combinationally on both valids.
  - On handshake: latch op, src1 and src2 into op_r, a_r and b_r; record gnt_r; update last_grant; go to EXEC.
  - No valid: stay in IDLE; last_grant is unchanged.
- EXEC:
  - alu_enable=1; alu_op/src1/src2 driven from the latched registers.
  - At the clock edge, capture alu_result into rsp_data and alu_ovf into rsp_overflow; go to RESP.
- RESP:
  - rsp[gnt_r]_valid=1. The other rsp valid is 0.
  - Held stable until rsp[gnt_r]_ready=1, then go to IDLE.
  - The non-granted requester's rsp_ready is ignored.
- Outside EXEC: alu_enable=0. alu_op/src1/src2 keep their latched values; they are never X after reset.
- Reset values: all ready/valid outputs 0, rsp_data 0, rsp_overflow 0, alu_enable 0, alu_op/src regs 0, sticky flags 0, last_grant 1.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded with no response, and the block returns to IDLE next cycle.
- Requester valid dropped without ready: legal; no state change.
- Opcodes are passed through unchecked. Unknown opcodes still complete; the result is whatever the ALU returns.

## Timing
- Accept in cycle N (IDLE, handshake) -> ALU driven in N+1 -> rspX_valid=1 in N+2.
- Best-case throughput is one op per 3 cycles: rsp_ready=1 in N+2 allows the next accept in N+3.
- Response backpressure stalls in RESP indefinitely. No new request is accepted meanwhile.
- rsp_data/rsp_overflow change only at the EXEC->RESP edge.
- Fairness: with both valid continuously, grants alternate 0,1,0,1…

## Configuration
- ALU_ARB_STICKY_OVF_EN defined:
  - At the EXEC->RESP edge, if alu_ovf=1, set ovf_sticky[gnt_r].
  - ovf_clr=1 clears both flags; a clear in the same cycle as a set leaves the flag set (set wins).
- Undefined: ovf_sticky0/1 tied to 0, ovf_clr ignored, no sticky flops generated.

## Test plan
- Reset: hold rst_n=0 2 cycles with req0_valid=1 -> all ready/valid 0, alu_enable 0; first grant after release goes to req0.
- Single op: req0 ADD(5'b00000) 5+7, rsp0_ready=1 -> alu_enable=1 exactly one cycle; rsp0_valid at N+2 with rsp_data=12, rsp_overflow=0; rsp1_valid stays 0.
- Contention: both valid continuously, req0 SUB 10-3, req1 AND 0xF0F0&0x0FF0 -> grants alternate 0,1,0; results 7 and 0x00F0 routed to the correct rsp valid.
- Backpressure: rsp1_ready=0 for 5 cycles -> rsp1_valid/rsp_data stable, both req_ready 0, alu_enable 0; completes the cycle rsp1_ready=1.
- Overflow/sticky (macro on): req1 ADD 0x7FFFFFFF+1 -> rsp_data=0x80000000, rsp_overflow=1, ovf_sticky1=1, ovf_sticky0=0; ovf_clr pulse clears it. Macro off: ovf_sticky1 stays 0.
- Reset in RESP: rst_n=0 while rsp0_valid=1 -> next cycle rsp0_valid=0 and state IDLE; no stale response after release.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Define ALU_ARB_STICKY_OVF_EN to build the per-requester sticky overflow flags.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_overflow,

    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,

    output logic              ovf_sticky0,
    output logic              ovf_sticky1,
    input  logic              ovf_clr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]               state;
    logic                     last_grant;
    logic                     gnt_r;
    logic [OP_W-1:0]          op_r;
    logic signed [DATA_W-1:0] a_r;
    logic signed [DATA_W-1:0] b_r;

    logic grant;
    logic any_valid;
    logic idle_live;
    logic rsp_live;
    logic rsp_taken;

    // Both valid: favour whoever was not served last; otherwise the lone requester.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        if (v0 && v1)
            return ~last;
        return v1;
    endfunction

    assign grant     = pick_grant(req0_valid, req1_valid, last_grant);
    assign any_valid = req0_valid | req1_valid;
    assign idle_live = rst_n && (state == IDLE);
    assign rsp_live  = rst_n && (state == RESP);
    assign rsp_taken = gnt_r ? rsp1_ready : rsp0_ready;

    assign req0_ready = idle_live && req0_valid && !grant;
    assign req1_ready = idle_live && req1_valid && grant;

    assign rsp0_valid = rsp_live && !gnt_r;
    assign rsp1_valid = rsp_live && gnt_r;

    assign alu_enable = rst_n && (state == EXEC);
    assign alu_op     = op_r;
    assign alu_src1   = a_r;
    assign alu_src2   = b_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            gnt_r        <= 1'b0;
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_r       <= grant ? req1_op   : req0_op;
                        a_r        <= grant ? req1_src1 : req0_src1;
                        b_r        <= grant ? req1_src2 : req0_src2;
                        gnt_r      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                // ALU is driven for this single cycle; capture its output at the edge.
                EXEC: begin
                    rsp_data     <= alu_result;
                    rsp_overflow <= alu_ovf;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_taken)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STICKY_OVF_EN
    // Clear is applied first so a set in the same cycle wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky0 <= 1'b0;
            ovf_sticky1 <= 1'b0;
        end else begin
            if (ovf_clr) begin
                ovf_sticky0 <= 1'b0;
                ovf_sticky1 <= 1'b0;
            end
            if ((state == EXEC) && alu_ovf) begin
                if (gnt_r)
                    ovf_sticky1 <= 1'b1;
                else
                    ovf_sticky0 <= 1'b1;
            end
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign ovf_sticky0    = 1'b0;
    assign ovf_sticky1    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level reference model plus literal checks.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp_data;
    logic        rsp_overflow;
    logic        alu_enable;
    logic [4:0]  alu_op;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_ovf;
    logic        ovf_sticky0, ovf_sticky1, ovf_clr;

`ifdef ALU_ARB_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.DATA_W(32), .OP_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
        .alu_enable(alu_enable), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .alu_ovf(alu_ovf),
        .ovf_sticky0(ovf_sticky0), .ovf_sticky1(ovf_sticky1), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference ALU: {overflow, result}. Unknown opcodes return a recognisable pattern.
    function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (op)
            5'd0: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            5'd1: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a ^ b;
            default: r = a ^ 32'hA5A5_0000;
        endcase
        return {v, r};
    endfunction

    // The ALU answers only while enabled; otherwise it shows junk a wrong capture would expose.
    logic [32:0] alu_full;
    always_comb begin
        alu_full = ref_alu(alu_op, alu_src1, alu_src2);
        if (alu_enable) begin
            alu_result = alu_full[31:0];
            alu_ovf    = alu_full[32];
        end else begin
            alu_result = 32'hDEAD_BEEF;
            alu_ovf    = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: one op in flight, aged in cycles since its acceptance.
    bit          m_run  = 0;
    bit          m_busy = 0;
    int          m_age  = 0;
    bit          m_who  = 0;
    bit          m_last = 1;
    logic [4:0]  m_op   = '0;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0, m_data = '0;
    bit          m_ovf = 0, m_dovf = 0, m_st0 = 0, m_st1 = 0;

    function bit model_grant();
        if (req0_valid && req1_valid)
            return !m_last;
        return req1_valid;
    endfunction

    always @(posedge clk) begin
        logic [32:0] full;
        bit          g;
        m_run = 1;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_op = '0; m_a = '0; m_b = '0;
            m_data = '0; m_dovf = 0; m_st0 = 0; m_st1 = 0;
        end else begin
            if (STICKY && ovf_clr) begin
                m_st0 = 0;
                m_st1 = 0;
            end
            if (!m_busy) begin
                if (req0_valid || req1_valid) begin
                    g      = model_grant();
                    m_who  = g;
                    m_last = g;
                    m_op   = g ? req1_op   : req0_op;
                    m_a    = g ? req1_src1 : req0_src1;
                    m_b    = g ? req1_src2 : req0_src2;
                    full   = ref_alu(m_op, m_a, m_b);
                    m_res  = full[31:0];
                    m_ovf  = full[32];
                    m_busy = 1;
                    m_age  = 1;
                end
            end else if (m_age == 1) begin
                m_data = m_res;
                m_dovf = m_ovf;
                if (STICKY && m_ovf) begin
                    if (m_who) m_st1 = 1;
                    else       m_st0 = 1;
                end
                m_age = 2;
            end else if ((!m_who && rsp0_ready) || (m_who && rsp1_ready)) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        bit g;
        bit free;
        if (m_run) begin
            g    = model_grant();
            free = !m_busy;
            chk("req0_ready", 32'(req0_ready), 32'(rst_n && free && req0_valid && !g));
            chk("req1_ready", 32'(req1_ready), 32'(rst_n && free && req1_valid && g));
            chk("rsp0_valid", 32'(rsp0_valid), 32'(rst_n && m_busy && m_age >= 2 && !m_who));
            chk("rsp1_valid", 32'(rsp1_valid), 32'(rst_n && m_busy && m_age >= 2 && m_who));
            chk("alu_enable", 32'(alu_enable), 32'(rst_n && m_busy && m_age == 1));
            chk("alu_op", 32'(alu_op), 32'(m_op));
            chk("alu_src1", alu_src1, m_a);
            chk("alu_src2", alu_src2, m_b);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_overflow", 32'(rsp_overflow), 32'(m_dovf));
            chk("ovf_sticky0", 32'(ovf_sticky0), 32'(m_st0));
            chk("ovf_sticky1", 32'(ovf_sticky1), 32'(m_st1));
        end
    end

    initial begin
        rst_n = 0; ovf_clr = 0;
        req0_valid = 1; req0_op = '0; req0_src1 = '0; req0_src2 = '0;
        req1_valid = 0; req1_op = '0; req1_src1 = '0; req1_src2 = '0;
        rsp0_ready = 0; rsp1_ready = 0;

        tick(); tick();
        @(negedge clk);
        chk("lit_rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("lit_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("lit_rst_alu_enable", 32'(alu_enable), 32'd0);
        chk("lit_rst_rsp_data", rsp_data, 32'd0);

        // Single ADD from req0
        tick();
        rst_n = 1; req0_op = 5'd0; req0_src1 = 32'd5; req0_src2 = 32'd7; rsp0_ready = 1;
        @(negedge clk);
        chk("lit_first_grant_req0", 32'(req0_ready), 32'd1);
        chk("lit_first_grant_req1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 0;
        @(negedge clk);
        chk("lit_add_alu_enable", 32'(alu_enable), 32'd1);
        chk("lit_add_alu_src1", alu_src1, 32'd5);
        tick();
        @(negedge clk);
        chk("lit_add_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("lit_add_rsp_data", rsp_data, 32'd12);
        chk("lit_add_model_data", m_data, 32'd12);
        chk("lit_add_rsp1_valid", 32'(rsp1_valid), 32'd0);
        chk("lit_add_alu_enable_off", 32'(alu_enable), 32'd0);

        // Contention: req0 was served last, so req1 goes first
        tick();
        req0_valid = 1; req0_op = 5'd1; req0_src1 = 32'd10; req0_src2 = 32'd3;
        req1_valid = 1; req1_op = 5'd2; req1_src1 = 32'h0000_F0F0; req1_src2 = 32'h0000_0FF0;
        rsp1_ready = 1;
        @(negedge clk);
        chk("lit_cont_g1_req1_ready", 32'(req1_ready), 32'd1);
        chk("lit_cont_g1_req0_ready", 32'(req0_ready), 32'd0);
        tick(); tick();
        @(negedge clk);
        chk("lit_cont_and_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("lit_cont_and_rsp_data", rsp_data, 32'h0000_00F0);
        tick();
        @(negedge clk);
        chk("lit_cont_g2_req0_ready", 32'(req0_ready), 32'd1);
        tick(); tick();
        @(negedge clk);
        chk("lit_cont_sub_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("lit_cont_sub_rsp_data", rsp_data, 32'd7);
        tick();
        @(negedge clk);
        chk("lit_cont_g3_req1_ready", 32'(req1_ready), 32'd1);

        // Backpressure on req1's response while req0 keeps asking
        tick();
        req1_valid = 0; rsp1_ready = 0;
        req0_op = 5'd4; req0_src1 = 32'h0000_00FF; req0_src2 = 32'h0000_000F;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_stall_rsp1_valid", 32'(rsp1_valid), 32'd1);
            chk("lit_stall_rsp_data", rsp_data, 32'h0000_00F0);
            chk("lit_stall_req0_ready", 32'(req0_ready), 32'd0);
            chk("lit_stall_alu_enable", 32'(alu_enable), 32'd0);
            tick();
        end
        rsp1_ready = 1;
        req1_valid = 1; req1_op = 5'd0; req1_src1 = 32'h7FFF_FFFF; req1_src2 = 32'd1;
        @(negedge clk);
        chk("lit_stall_release_rsp1_valid", 32'(rsp1_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("lit_post_stall_req0_ready", 32'(req0_ready), 32'd1);
        chk("lit_post_stall_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        chk("lit_xor_rsp_data", rsp_data, 32'h0000_00F0);

        // Signed overflow on req1
        tick();
        @(negedge clk);
        chk("lit_ovf_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 0;
        tick();
        @(negedge clk);
        chk("lit_ovf_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("lit_ovf_rsp_data", rsp_data, 32'h8000_0000);
        chk("lit_ovf_rsp_overflow", 32'(rsp_overflow), 32'd1);
        chk("lit_ovf_sticky1", 32'(ovf_sticky1), 32'(STICKY));
        chk("lit_ovf_sticky0", 32'(ovf_sticky0), 32'd0);
        tick();
        ovf_clr = 1;
        @(negedge clk);
        chk("lit_ovf_sticky1_held", 32'(ovf_sticky1), 32'(STICKY));
        tick();
        ovf_clr = 0;
        @(negedge clk);
        chk("lit_ovf_sticky1_cleared", 32'(ovf_sticky1), 32'd0);

        // Unknown opcode still completes with whatever the ALU returned
        tick();
        req0_valid = 1; req0_op = 5'h1F; req0_src1 = 32'd3; req0_src2 = 32'd9;
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        chk("lit_unk_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("lit_unk_rsp_data", rsp_data, 32'hA5A5_0003);

        // Reset while a response is pending
        tick();
        rsp0_ready = 0;
        req0_valid = 1; req0_op = 5'd3; req0_src1 = 32'd1; req0_src2 = 32'd2;
        tick();
        req0_valid = 0;
        tick();
        @(negedge clk);
        chk("lit_rr_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("lit_rr_rsp_data", rsp_data, 32'd3);
        tick();
        rst_n = 0;
        @(negedge clk);
        chk("lit_rr_in_reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
        tick();
        rst_n = 1; rsp0_ready = 1;
        @(negedge clk);
        chk("lit_rr_after_rsp0_valid", 32'(rsp0_valid), 32'd0);
        chk("lit_rr_after_rsp_data", rsp_data, 32'd0);
        tick();
        @(negedge clk);
        chk("lit_rr_no_stale", 32'(rsp0_valid), 32'd0);

        // Fresh op after reset recovery
        tick();
        req1_valid = 1; req1_op = 5'd1; req1_src1 = 32'd3; req1_src2 = 32'd5;
        tick();
        req1_valid = 0;
        tick();
        @(negedge clk);
        chk("lit_final_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("lit_final_rsp_data", rsp_data, 32'hFFFF_FFFE);
        chk("lit_final_rsp_overflow", 32'(rsp_overflow), 32'd0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
